// File: rtl/alu_sub16_serial.sv
// -----------------------------------------------------------------------------
// alu_sub16_serial
//
// Digit-serial unsigned subtractor. It computes out = a - b (mod 2^WIDTH) as
// a + ~b + 1. It works on DIGIT bits per clock, least-significant digit first,
// so a full operation takes N = WIDTH/DIGIT clocks. It is the low-area partner
// of the combinational ALU adder. A start/busy/done handshake sequences it.
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request; sampled only while idle (busy=0)
//   a, b    minuend / subtrahend, captured on the accepting edge
//   busy    operation in progress
//   done    one-cycle pulse when out/borrow/zero are updated
//   out     difference a - b mod 2^WIDTH (held until the next completion)
//   borrow  1 iff a < b (unsigned), i.e. the inverted final carry
//   zero    1 iff out == 0
//
// DIGIT must divide WIDTH.
// -----------------------------------------------------------------------------
module alu_sub16_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             zero
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] nb_q,     nb_d;     // inverted subtrahend
  logic             carry_q,  carry_d;
  logic [WIDTH-1:0] res_q,    res_d;    // result shift register
  logic [WIDTH-1:0] out_q,    out_d;
  logic             borrow_q, borrow_d;
  logic             zero_q,   zero_d;
  logic             done_q,   done_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic [WIDTH-1:0] res_shift;

  // Ripple chain of DIGIT full-adder cells on the current low digit.
  always_comb begin
    logic c;
    dig_sum = '0;
    c       = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      dig_sum[i] = a_q[i] ^ nb_q[i] ^ c;
      c          = (a_q[i] & nb_q[i]) | (c & (a_q[i] ^ nb_q[i]));
    end
    dig_cout = c;
  end

  // New digit enters at the MSB side. After N shifts the first digit sits at
  // the LSB position. Shift form keeps this legal when DIGIT == WIDTH.
  assign res_shift = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    nb_d     = nb_q;
    carry_d  = carry_q;
    res_d    = res_q;
    out_d    = out_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          nb_d    = ~b;
          carry_d = 1'b1;           // the +1 of the two's complement
          res_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        nb_d    = nb_q >> DIGIT;
        carry_d = dig_cout;
        res_d   = res_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_IDLE;
          out_d    = res_shift;
          borrow_d = ~dig_cout;
          zero_d   = (res_shift == '0);
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      nb_q     <= '0;
      carry_q  <= 1'b0;
      res_q    <= '0;
      out_q    <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      nb_q     <= nb_d;
      carry_q  <= carry_d;
      res_q    <= res_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = done_q;
  assign out    = out_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_sub16_serial.sv
// -----------------------------------------------------------------------------
// tb_alu_sub16_serial
//
// Bench for alu_sub16_serial. It instantiates one DIGIT=1 and one DIGIT=4
// instance. Each issued operation pushes its hand-computed response and
// completion cycle into a queue. A monitor per instance pops the entry and
// compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_alu_sub16_serial;

  localparam int W  = 16;
  localparam int N1 = 16;
  localparam int N4 = 4;

  typedef struct {
    logic [15:0] out;
    logic        borrow;
    logic        zero;
    int          cyc;
  } exp_t;

  logic clk, rst_n;
  logic start, start4;
  logic [W-1:0] a, b, a4, b4;
  logic busy, done, borrow, zero;
  logic busy4, done4, borrow4, zero4;
  logic [W-1:0] out, out4;

  int cyc = 0;
  int total = 0;
  int passed = 0;
  exp_t q[$];
  exp_t q4[$];

  alu_sub16_serial #(.WIDTH(16), .DIGIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .out(out), .borrow(borrow), .zero(zero)
  );

  alu_sub16_serial #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .out(out4), .borrow(borrow4), .zero(zero4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitors: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      chk("d1_busy_with_done", busy, 1'b0);
      if (q.size() == 0) begin
        chk("d1_unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("d1_out", out, e.out);
        chk("d1_borrow", borrow, e.borrow);
        chk("d1_zero", zero, e.zero);
        chk("d1_done_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4) begin
      exp_t e;
      chk("d4_busy_with_done", busy4, 1'b0);
      if (q4.size() == 0) begin
        chk("d4_unexpected_done", 1, 0);
      end else begin
        e = q4.pop_front();
        chk("d4_out", out4, e.out);
        chk("d4_borrow", borrow4, e.borrow);
        chk("d4_zero", zero4, e.zero);
        chk("d4_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at posedge+1: start is taken on the next edge (cyc+1). Done is
  // then high during the cycle after N more edges.
  task automatic issue(input bit sel4, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] eo, input logic eb, input logic ez);
    exp_t e;
    e.out = eo; e.borrow = eb; e.zero = ez;
    if (sel4) begin
      e.cyc = cyc + 1 + N4;
      q4.push_back(e);
      a4 = av; b4 = bv; start4 = 1'b1;
    end else begin
      e.cyc = cyc + 1 + N1;
      q.push_back(e);
      a = av; b = bv; start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && q4.size() == 0 && !busy && !busy4) break;
      @(posedge clk); #1;
    end
    chk("drain_pending", q.size() + q4.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
    a = '0; b = '0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", out, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_zero", zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic operation.
    issue(0, 16'h1234, 16'h0234, 16'h1000, 0, 0);
    chk("busy_after_start", busy, 1);
    drain();
    chk("hold_out", out, 16'h1000);
    chk("hold_borrow", borrow, 0);

    // Borrow cases.
    issue(0, 16'h0000, 16'h0001, 16'hFFFF, 1, 0);
    drain();
    issue(0, 16'h8000, 16'hFFFF, 16'h8001, 1, 0);
    drain();

    // Zero result and no-borrow max.
    issue(0, 16'hABCD, 16'hABCD, 16'h0000, 0, 1);
    drain();
    issue(0, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 0);
    drain();

    // Start while busy is ignored; operand changes after acceptance are harmless.
    issue(0, 16'h0010, 16'h0001, 16'h000F, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    a = 16'h9999; b = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'h5555; b = 16'hAAAA;
    drain();

    // Back-to-back: second start lands in the first done cycle.
    issue(0, 16'h0005, 16'h0003, 16'h0002, 0, 0);
    repeat (N1) @(posedge clk);
    #1;
    chk("b2b_done_cycle", done, 1);
    issue(0, 16'h0003, 16'h0005, 16'hFFFE, 1, 0);
    chk("b2b_busy_no_gap", busy, 1);
    drain();

    // Reset mid-run: outputs clear at once and no done follows.
    issue(0, 16'h1234, 16'h0234, 16'h1000, 0, 0);
    drain();
    issue(0, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_out", out, 0);
    chk("abort_borrow", borrow, 0);
    chk("abort_zero", zero, 0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("abort_out_after", out, 0);

    // DIGIT=4 instance.
    issue(1, 16'h1234, 16'h0234, 16'h1000, 0, 0);
    drain();
    issue(1, 16'h0000, 16'h0001, 16'hFFFF, 1, 0);
    drain();
    issue(1, 16'hABCD, 16'hABCD, 16'h0000, 0, 1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_sub16_serial.md
Name: alu_sub16_serial

Overview:
- Multi-cycle unsigned subtractor. It computes out = a - b on WIDTH-bit operands, DIGIT bits per clock, LSB first, using two's-complement addition (a + ~b + 1).
- It is the subtraction counterpart of the combinational 16-bit ALU adder. It reports borrow (a < b) and a zero result.
- It sits in the ALU datapath next to the adder and is used where area matters more than latency. A start/busy/done handshake sequences it.

Parameters:
- WIDTH, 16, operand and result width in bits.
- DIGIT, 1, bits processed per clock. Must divide WIDTH (1, 2, 4, 8, 16). N = WIDTH/DIGIT is the cycle count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  minuend; captured on the accepting edge
- b  input  WIDTH  subtrahend; captured on the accepting edge
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; out, borrow and zero are valid
- out  output  WIDTH  difference a - b mod 2^WIDTH
- borrow  output  1  1 iff a < b (unsigned), i.e. NOT final carry
- zero  output  1  1 iff out == 0

Behaviour:
- Reset (rst_n=0, async): state IDLE; busy=0, done=0, out=0, borrow=0, zero=0; internal registers cleared.
- States:
  - IDLE: busy=0.
  - RUN: busy=1. Contains a digit counter 0..N-1.
- IDLE -> RUN on a rising edge with start=1:
  - latch a, ~b and carry=1;
  - clear the result shift register;
  - counter=0.
- RUN, each edge:
  - add the low DIGIT bits of a_reg, ~b_reg and carry;
  - shift the sum into the result from the MSB side;
  - shift a_reg and b_reg right by DIGIT;
  - update carry; increment counter.
- RUN -> IDLE on the edge where counter==N-1. On that same edge:
  - out <= final result; borrow <= ~carry_out; zero <= (final result == 0);
  - done <= 1 for exactly one cycle; busy <= 0.
- Latency: start accepted at edge E0, done high during the cycle after edge E0+N. For WIDTH=16, DIGIT=1, done follows 16 RUN edges.
- out, borrow and zero hold their values until the next completion. Only reset or the next completion changes them; they are not cleared on start.
- start while busy=1 is ignored. a and b may change freely after acceptance without affecting the result.
- start=1 in the done cycle (state IDLE) is accepted: back-to-back operation, no dead cycle.
- done is never asserted in the same cycle as busy.
- Reset mid-RUN aborts the operation: no done pulse, and all outputs return to reset values.
- No overflow/sign logic: the operation is unsigned. Borrow is the only range indicator.
- Combinational per-digit adder: DIGIT full-adder cells chained on carry. No other arithmetic operators on the full width.

Test Plan:
- WIDTH=16, DIGIT=1, a=0x1234, b=0x0234, start for 1 cycle -> busy=1 for 16 cycles, then done=1 one cycle with out=0x1000, borrow=0, zero=0.
- a=0x0000, b=0x0001 -> out=0xFFFF, borrow=1, zero=0. Also a=0x8000, b=0xFFFF -> out=0x8001, borrow=1.
- a=0xABCD, b=0xABCD -> out=0x0000, borrow=0, zero=1. Also a=0xFFFF, b=0x0000 -> out=0xFFFF, borrow=0.
- Start a=0x0010, b=0x0001; at cycle 5 pulse start with a=0x9999, b=0x1111 and change a/b -> second start ignored; result 0x000F, borrow=0; exactly one done.
- Start 0x0005-0x0003; on its done cycle assert start with 0x0003-0x0005 -> first done out=0x0002, borrow=0. The next N cycles busy=1; the second done out=0xFFFE, borrow=1; no idle gap.
- Reset and digit width:
  - Previous result 0x1000 held; start a new op; drop rst_n at RUN cycle 7 -> busy=0, done=0, out=0, borrow=0, zero=0 immediately; no done afterwards.
  - Re-run with DIGIT=4: 0x1234-0x0234 -> done after 4 RUN edges, out=0x1000.
